ldst_control_unit: RTL

Hardwired control sequencer for the instruction fetch and the memory-class instructions ld, ldi and st. It drives the datapath's control inputs (PCout, MARin, Read, MDRin, Gra/Grb, Rin/Rout, BAout, Cout, ALU opcode, and the rest) that were previously stepped by hand. It sits beside datapath, consumes the IR contents, and produces exactly one control step per clock.

---
 rtl/cpu_ctrl_pkg.sv | 76 +++++++
 rtl/ldst_control_unit_if.sv | 23 ++
 rtl/ctrl_decode.sv | 91 +++++++++
 rtl/ldst_control_unit.sv | 71 +++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the ld/ldi/st control sequencer.
// State encoding, opcode values, IR field positions and the packed strobe vector.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      RESET = 4'd0,
      T0    = 4'd1,
      T1    = 4'd2,
      T2    = 4'd3,
      T3    = 4'd4,
      T4    = 4'd5,
      T5    = 4'd6,
      T6    = 4'd7,
      T7    = 4'd8,
      HALT  = 4'd9
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] ALU_ADD = 5'b00011;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int C_HI   = 18;
   localparam int C_LO   = 0;

   typedef struct packed {
      logic [4:0] opcode;
      logic       PCout;
      logic       MARin;
      logic       IncPC;
      logic       Zin;
      logic       Zlowout;
      logic       PCin;
      logic       Read;
      logic       Write;
      logic       MDRin;
      logic       MDRout;
      logic       IRin;
      logic       Gra;
      logic       Grb;
      logic       Rin;
      logic       Rout;
      logic       BAout;
      logic       Yin;
      logic       Cout;
      logic       Run;
      logic       Illegal;
   } ctrl_t;

   function automatic logic [4:0] ir_opc(input logic [31:0] ir);
      return ir[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [3:0] ir_ra(input logic [31:0] ir);
      return ir[RA_HI:RA_LO];
   endfunction

   function automatic logic [3:0] ir_rb(input logic [31:0] ir);
      return ir[RB_HI:RB_LO];
   endfunction

   function automatic logic [18:0] ir_c(input logic [31:0] ir);
      return ir[C_HI:C_LO];
   endfunction

   function automatic logic is_mem_op(input logic [4:0] opc);
      return (opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST);
   endfunction

endpackage

// File: rtl/ldst_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/Stop toward the sequencer, strobes toward the datapath.
// No handshake: one control step per clock, datapath always accepts.
interface ldst_control_unit_if;
   logic [31:0] IR;
   logic        Stop;
   logic [4:0]  opcode;
   logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin;
   logic        Gra, Grb, Rin, Rout, BAout, Yin, Cout;
   logic        Run;
   logic        Illegal;

   modport master (
      input  IR, Stop,
      output opcode, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin,
             Gra, Grb, Rin, Rout, BAout, Yin, Cout, Run, Illegal
   );

   modport slave (
      output IR, Stop,
      input  opcode, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin,
             Gra, Grb, Rin, Rout, BAout, Yin, Cout, Run, Illegal
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational (state, opcode) -> strobe vector; zero latency.
// RESET and HALT decode to all-zero, so reset clears every output in the same delta.
module ctrl_decode #(
   parameter logic [4:0] ALU_ADD = cpu_ctrl_pkg::ALU_ADD
) (
   input  cpu_ctrl_pkg::state_t state,
   input  logic [4:0]           opc,
   output cpu_ctrl_pkg::ctrl_t  ctl
);
   import cpu_ctrl_pkg::*;

   logic is_ld, is_ldi, is_st;

   always_comb begin
      is_ld  = (opc == OP_LD);
      is_ldi = (opc == OP_LDI);
      is_st  = (opc == OP_ST);
   end

   always_comb begin
      ctl = '0;
      case (state)
         T0: begin
            ctl.Run   = 1'b1;
            ctl.PCout = 1'b1;
            ctl.MARin = 1'b1;
            ctl.IncPC = 1'b1;
            ctl.Zin   = 1'b1;
         end
         T1: begin
            ctl.Run     = 1'b1;
            ctl.Zlowout = 1'b1;
            ctl.PCin    = 1'b1;
            ctl.Read    = 1'b1;
            ctl.MDRin   = 1'b1;
         end
         T2: begin
            ctl.Run     = 1'b1;
            ctl.MDRout  = 1'b1;
            ctl.IRin    = 1'b1;
            ctl.Illegal = !(is_ld || is_ldi || is_st);
         end
         T3: begin
            ctl.Run   = 1'b1;
            ctl.Grb   = 1'b1;
            ctl.BAout = 1'b1;
            ctl.Yin   = 1'b1;
         end
         T4: begin
            ctl.Run    = 1'b1;
            ctl.Cout   = 1'b1;
            ctl.opcode = ALU_ADD;
            ctl.Zin    = 1'b1;
         end
         T5: begin
            ctl.Run     = 1'b1;
            ctl.Zlowout = 1'b1;
            if (is_ldi) begin
               ctl.Gra = 1'b1;
               ctl.Rin = 1'b1;
            end else begin
               ctl.MARin = 1'b1;
            end
         end
         T6: begin
            ctl.Run = 1'b1;
            // For st, Read stays low so MDR captures Ra from the bus instead of memory.
            if (is_st) begin
               ctl.Gra   = 1'b1;
               ctl.Rout  = 1'b1;
               ctl.MDRin = 1'b1;
            end else if (is_ld) begin
               ctl.Read  = 1'b1;
               ctl.MDRin = 1'b1;
            end
         end
         T7: begin
            ctl.Run = 1'b1;
            if (is_st) begin
               ctl.Write = 1'b1;
            end else if (is_ld) begin
               ctl.MDRout = 1'b1;
               ctl.Gra    = 1'b1;
               ctl.Rin    = 1'b1;
            end
         end
         default: ctl = '0;
      endcase
   end

endmodule

// File: rtl/ldst_control_unit.sv
// Hardwired fetch + ld/ldi/st sequencer: one control step per Clock, Stop honoured at instruction end.
// Latency from T0: ld/st 8, ldi 6, illegal 3 cycles; no backpressure from the datapath.
module ldst_control_unit #(
   parameter logic [4:0] ALU_ADD = cpu_ctrl_pkg::ALU_ADD
) (
   input logic                 Clock,
   input logic                 clear,
   ldst_control_unit_if.master bus
);
   import cpu_ctrl_pkg::*;

   state_t     state, state_nxt;
   ctrl_t      ctl;
   logic [4:0] opc;
   logic       unused_ir;

   assign opc       = ir_opc(bus.IR);
   assign unused_ir = ^bus.IR[RA_HI:C_LO];

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) state <= RESET;
      else        state <= state_nxt;
   end

   // Stop only matters on the last step of an instruction and while halted.
   always_comb begin
      state_nxt = state;
      case (state)
         RESET:   state_nxt = T0;
         T0:      state_nxt = T1;
         T1:      state_nxt = T2;
         T2:      state_nxt = is_mem_op(opc) ? T3 : (bus.Stop ? HALT : T0);
         T3:      state_nxt = T4;
         T4:      state_nxt = T5;
         T5:      state_nxt = (opc == OP_LDI) ? (bus.Stop ? HALT : T0) : T6;
         T6:      state_nxt = T7;
         T7:      state_nxt = bus.Stop ? HALT : T0;
         HALT:    state_nxt = bus.Stop ? HALT : T0;
         default: state_nxt = RESET;
      endcase
   end

   ctrl_decode #(.ALU_ADD(ALU_ADD)) u_decode (
      .state (state),
      .opc   (opc),
      .ctl   (ctl)
   );

   assign bus.opcode  = ctl.opcode;
   assign bus.PCout   = ctl.PCout;
   assign bus.MARin   = ctl.MARin;
   assign bus.IncPC   = ctl.IncPC;
   assign bus.Zin     = ctl.Zin;
   assign bus.Zlowout = ctl.Zlowout;
   assign bus.PCin    = ctl.PCin;
   assign bus.Read    = ctl.Read;
   assign bus.Write   = ctl.Write;
   assign bus.MDRin   = ctl.MDRin;
   assign bus.MDRout  = ctl.MDRout;
   assign bus.IRin    = ctl.IRin;
   assign bus.Gra     = ctl.Gra;
   assign bus.Grb     = ctl.Grb;
   assign bus.Rin     = ctl.Rin;
   assign bus.Rout    = ctl.Rout;
   assign bus.BAout   = ctl.BAout;
   assign bus.Yin     = ctl.Yin;
   assign bus.Cout    = ctl.Cout;
   assign bus.Run     = ctl.Run;
   assign bus.Illegal = ctl.Illegal;

endmodule
